// File: rtl/div_pkg.sv
// Shared divider definitions: FSM encodings, handshake/mode constants and the
// EX-side opcode hooks so EX and div agree on the same encodings.
package div_pkg;

   localparam int unsigned DivWidth = 32;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivAnnul          = 1'b1;
   localparam logic DivNotAnnul       = 1'b0;
   localparam logic DivSigned         = 1'b1;
   localparam logic DivUnsigned       = 1'b0;

   // EX-stage hooks for issuing DIV/DIVU
   localparam logic [7:0] ExeDivOp   = 8'b0001_1010;
   localparam logic [7:0] ExeDivuOp  = 8'b0001_1011;
   localparam logic [5:0] FunctDiv   = 6'b01_1010;
   localparam logic [5:0] FunctDivu  = 6'b01_1011;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor, and keep the difference only when it is non-negative.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DivWidth
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem_c,
   output logic [WIDTH-1:0] o_quo_c
);

   logic [WIDTH:0] w_shifted;
   logic [WIDTH:0] w_trial;

   // One extra bit: the shifted remainder can exceed 2^WIDTH for large divisors
   assign w_shifted = {i_rem, i_quo[WIDTH-1]};
   assign w_trial   = w_shifted - {1'b0, i_divisor};

   always_comb begin
      o_rem_c = w_shifted[WIDTH-1:0];
      o_quo_c = {i_quo[WIDTH-2:0], 1'b0};
      if (!w_trial[WIDTH]) begin
         o_rem_c    = w_trial[WIDTH-1:0];
         o_quo_c[0] = 1'b1;
      end
   end

endmodule

// File: rtl/div.sv
// Multi-cycle iterative divider for the EX stage: one quotient bit per cycle,
// returns {remainder, quotient} with ready_o releasing the pipeline stall.
module div
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DivWidth
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   div_state_e            r_state, w_state_nxt;
   logic [CntW-1:0]       r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0]      r_rem, w_rem_nxt;
   logic [WIDTH-1:0]      r_quo, w_quo_nxt;
   logic [WIDTH-1:0]      r_divisor, w_divisor_nxt;
   logic                  r_neg_quo, w_neg_quo_nxt;
   logic                  r_neg_rem, w_neg_rem_nxt;
   logic [2*WIDTH-1:0]    w_result_nxt;
   logic                  w_ready_nxt;

   logic [WIDTH-1:0]      w_abs1, w_abs2;
   logic [WIDTH-1:0]      w_step_rem, w_step_quo;
   logic [WIDTH-1:0]      w_quo_fix, w_rem_fix;
   logic                  w_neg1, w_neg2;

   assign w_neg1    = signed_div_i && opdata1_i[WIDTH-1];
   assign w_neg2    = signed_div_i && opdata2_i[WIDTH-1];
   assign w_abs1    = w_neg1 ? WIDTH'(-opdata1_i) : opdata1_i;
   assign w_abs2    = w_neg2 ? WIDTH'(-opdata2_i) : opdata2_i;
   assign w_quo_fix = r_neg_quo ? WIDTH'(-r_quo) : r_quo;
   assign w_rem_fix = r_neg_rem ? WIDTH'(-r_rem) : r_rem;

   div_step #(
      .WIDTH     (WIDTH)
   ) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_divisor),
      .o_rem_c   (w_step_rem),
      .o_quo_c   (w_step_quo)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= DivFree;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_neg_quo <= 1'b0;
         r_neg_rem <= 1'b0;
         result_o  <= '0;
         ready_o   <= DivResultNotReady;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rem     <= w_rem_nxt;
         r_quo     <= w_quo_nxt;
         r_divisor <= w_divisor_nxt;
         r_neg_quo <= w_neg_quo_nxt;
         r_neg_rem <= w_neg_rem_nxt;
         result_o  <= w_result_nxt;
         ready_o   <= w_ready_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_rem_nxt     = r_rem;
      w_quo_nxt     = r_quo;
      w_divisor_nxt = r_divisor;
      w_neg_quo_nxt = r_neg_quo;
      w_neg_rem_nxt = r_neg_rem;
      w_result_nxt  = result_o;
      w_ready_nxt   = ready_o;

      case (r_state)
         DivFree: begin
            w_result_nxt = '0;
            w_ready_nxt  = DivResultNotReady;
            if (start_i == DivStart && annul_i == DivNotAnnul) begin
               if (opdata2_i == '0) begin
                  w_state_nxt = DivByZero;
               end else begin
                  w_state_nxt   = DivOn;
                  w_cnt_nxt     = '0;
                  w_rem_nxt     = '0;
                  w_quo_nxt     = w_abs1;
                  w_divisor_nxt = w_abs2;
                  w_neg_quo_nxt = w_neg1 ^ w_neg2;
                  w_neg_rem_nxt = w_neg1;
               end
            end
         end
         DivByZero: begin
            w_state_nxt  = DivEnd;
            w_result_nxt = '0;
            w_ready_nxt  = DivResultReady;
         end
         DivOn: begin
            if (annul_i == DivAnnul) begin
               w_state_nxt  = DivFree;
               w_result_nxt = '0;
               w_ready_nxt  = DivResultNotReady;
            end else if (r_cnt != CntW'(WIDTH)) begin
               w_rem_nxt = w_step_rem;
               w_quo_nxt = w_step_quo;
               w_cnt_nxt = r_cnt + CntW'(1);
            end else begin
               w_state_nxt  = DivEnd;
               w_result_nxt = {w_rem_fix, w_quo_fix};
               w_ready_nxt  = DivResultReady;
            end
         end
         DivEnd: begin
            if (start_i == DivStop) begin
               w_state_nxt  = DivFree;
               w_result_nxt = '0;
               w_ready_nxt  = DivResultNotReady;
            end
         end
         default: begin
            w_state_nxt = DivFree;
         end
      endcase
   end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the iterative divider.
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_errors = 0;

   div #(
      .WIDTH        (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue an operation, scramble operands after the sampling edge, and
   // report edges-to-ready (-1 on timeout) plus the result; start stays high.
   task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
      @(negedge clk);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      @(posedge clk);
      #1;
      opdata1_i    = ~a;
      opdata2_i    = 32'h0;
      signed_div_i = ~sg;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (ready_o) begin
            lat = k;
            break;
         end
      end
      res = result_o;
   endtask

   task automatic drop_start();
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = 32'h0; opdata2_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b0) begin
         n_errors++; $display("FAIL reset_ready: got %b expected 0", ready_o);
      end
      n_checks++;
      if (result_o !== 64'h0) begin
         n_errors++; $display("FAIL reset_result: got %h expected 0", result_o);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_divu_basic();
      int lat; logic [63:0] res;
      run_op(1'b0, 32'd100, 32'd7, lat, res);
      n_checks++;
      if (lat !== 33) begin
         n_errors++; $display("FAIL divu_100_7_latency: got %0d expected 33", lat);
      end
      n_checks++;
      if (res !== 64'h00000002_0000000E) begin
         n_errors++; $display("FAIL divu_100_7_result: got %h expected 000000020000000e", res);
      end
      drop_start();
      n_checks++;
      if (ready_o !== 1'b0) begin
         n_errors++; $display("FAIL drop_start_ready: got %b expected 0", ready_o);
      end
      n_checks++;
      if (result_o !== 64'h0) begin
         n_errors++; $display("FAIL drop_start_result: got %h expected 0", result_o);
      end
   endtask

   task automatic test_signed();
      logic [31:0] va [3] = '{32'hFFFFFFF9, 32'd7,        32'h80000000};
      logic [31:0] vb [3] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF};
      logic [63:0] ve [3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                              64'h00000000_80000000};
      int lat; logic [63:0] res;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b1, va[i], vb[i], lat, res);
         n_checks++;
         if (lat !== 33 || res !== ve[i]) begin
            n_errors++;
            $display("FAIL signed_div_%0d: got %h lat %0d expected %h lat 33", i, res, lat, ve[i]);
         end
         drop_start();
      end
   endtask

   task automatic test_unsigned_edges();
      logic [31:0] va [2] = '{32'hFFFFFFFF, 32'd5};
      logic [31:0] vb [2] = '{32'd1,        32'd9};
      logic [63:0] ve [2] = '{64'h00000000_FFFFFFFF, 64'h00000005_00000000};
      int lat; logic [63:0] res;
      for (int i = 0; i < 2; i++) begin
         run_op(1'b0, va[i], vb[i], lat, res);
         n_checks++;
         if (lat !== 33 || res !== ve[i]) begin
            n_errors++;
            $display("FAIL divu_edge_%0d: got %h lat %0d expected %h lat 33", i, res, lat, ve[i]);
         end
         drop_start();
      end
   endtask

   task automatic test_div_zero();
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0;
      start_i = 1'b1; annul_i = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b0) begin
         n_errors++; $display("FAIL divzero_early_ready: got %b expected 0", ready_o);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h0) begin
         n_errors++;
         $display("FAIL divzero_result: got ready %b result %h expected ready 1 result 0", ready_o, result_o);
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (ready_o !== 1'b1 || result_o !== 64'h0) begin
            n_errors++;
            $display("FAIL divzero_hold_%0d: got ready %b result %h expected ready 1 result 0", k, ready_o, result_o);
         end
      end
      drop_start();
      n_checks++;
      if (ready_o !== 1'b0) begin
         n_errors++; $display("FAIL divzero_release: got %b expected 0", ready_o);
      end
   endtask

   task automatic test_annul();
      int lat; logic [63:0] res;
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      start_i = 1'b1; annul_i = 1'b0;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         n_errors++;
         $display("FAIL annul_outputs: got ready %b result %h expected ready 0 result 0", ready_o, result_o);
      end
      // A quotient of 3 at exactly 33 edges shows the cancelled 100/7 is gone
      run_op(1'b0, 32'd9, 32'd3, lat, res);
      n_checks++;
      if (lat !== 33 || res !== 64'h00000000_00000003) begin
         n_errors++;
         $display("FAIL annul_restart: got %h lat %0d expected 0000000000000003 lat 33", res, lat);
      end
      drop_start();
   endtask

   task automatic test_async_reset();
      int lat; logic [63:0] res;
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      start_i = 1'b1; annul_i = 1'b0;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         n_errors++;
         $display("FAIL async_reset_mid: got ready %b result %h expected ready 0 result 0", ready_o, result_o);
      end
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_op(1'b0, 32'd8, 32'd2, lat, res);
      n_checks++;
      if (lat !== 33 || res !== 64'h00000000_00000004) begin
         n_errors++;
         $display("FAIL async_reset_restart: got %h lat %0d expected 0000000000000004 lat 33", res, lat);
      end
      // Reset with a result on the bus must clear it before the next edge
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         n_errors++;
         $display("FAIL async_reset_end: got ready %b result %h expected ready 0 result 0", ready_o, result_o);
      end
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_unsigned_edges();
      test_div_zero();
      test_annul();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
